// File: rtl/instr_prefetch_queue.sv
// Instruction fetch front-end: in-order imem requests, PC-tagged instruction FIFO,
// and redirect handling that flushes the FIFO and drains responses already in flight.
module instr_prefetch_queue #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned SW = CW + 1;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t          state, state_n;
   logic [XLEN-1:0] fetch_pc, fetch_pc_n;
   logic [CW-1:0]   count, count_n;
   logic [CW-1:0]   outstanding, outstanding_n;
   logic [CW-1:0]   stale, stale_n;
   logic [AW-1:0]   wr_ptr, wr_ptr_n;
   logic [AW-1:0]   rd_ptr, rd_ptr_n;
   logic [XLEN-1:0] inst_data_n, inst_pc_n;
   logic [XLEN-1:0] mem_data [DEPTH];
   logic [XLEN-1:0] mem_pc   [DEPTH];

   logic            accept;
   logic            rsp_ok;
   logic            push;
   logic            pop;
   logic [XLEN-1:0] rsp_pc;
   logic            unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // Credit rule: FIFO entries plus requests in flight never exceed DEPTH.
   always_comb begin : req_logic
      imem_req_valid = (state == FETCH) && !redirect_valid &&
                       ((SW'(count) + SW'(outstanding)) < SW'(DEPTH));
   end

   assign imem_req_addr = fetch_pc;
   assign inst_valid    = (count != '0);
   assign accept        = imem_req_valid && imem_req_ready;
   assign rsp_ok        = imem_rsp_valid && (outstanding != '0);
   assign push          = rsp_ok && (stale == '0) && !redirect_valid;
   assign pop           = inst_valid && inst_ready && !redirect_valid;

   // Live requests are contiguous and end at fetch_pc-4, so the oldest one is recoverable.
   assign rsp_pc = fetch_pc - XLEN'({outstanding, 2'b00});

   always_comb begin : next_state_logic
      state_n       = state;
      fetch_pc_n    = fetch_pc;
      count_n       = count + CW'(push) - CW'(pop);
      outstanding_n = outstanding + CW'(accept) - CW'(rsp_ok);
      stale_n       = stale;
      wr_ptr_n      = wr_ptr;
      rd_ptr_n      = rd_ptr;
      inst_data_n   = inst_data;
      inst_pc_n     = inst_pc;

      if (accept) begin
         fetch_pc_n = fetch_pc + XLEN'(4);
      end
      if (rsp_ok && (stale != '0)) begin
         stale_n = stale - CW'(1);
      end
      if (push) begin
         wr_ptr_n = wr_ptr + AW'(1);
      end
      if (pop) begin
         rd_ptr_n = rd_ptr + AW'(1);
      end

      // Head register follows the next FIFO head, bypassing a push into an empty queue.
      if (pop && (count > CW'(1))) begin
         inst_data_n = mem_data[rd_ptr + AW'(1)];
         inst_pc_n   = mem_pc[rd_ptr + AW'(1)];
      end else if (push && ((count == '0) || (pop && (count == CW'(1))))) begin
         inst_data_n = imem_rsp_data;
         inst_pc_n   = rsp_pc;
      end

      if (redirect_valid) begin
         fetch_pc_n = {redirect_pc[XLEN-1:2], 2'b00};
         count_n    = '0;
         wr_ptr_n   = '0;
         rd_ptr_n   = '0;
         stale_n    = outstanding_n;
      end

      case (state)
         BOOT:         state_n = FETCH;
         FETCH, DRAIN: state_n = (stale_n != '0) ? DRAIN : FETCH;
         default:      state_n = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin : state_regs
      if (!rst) begin
         state       <= BOOT;
         fetch_pc    <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         stale       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         inst_data   <= '0;
         inst_pc     <= '0;
      end else begin
         state       <= state_n;
         fetch_pc    <= fetch_pc_n;
         count       <= count_n;
         outstanding <= outstanding_n;
         stale       <= stale_n;
         wr_ptr      <= wr_ptr_n;
         rd_ptr      <= rd_ptr_n;
         inst_data   <= inst_data_n;
         inst_pc     <= inst_pc_n;
      end
   end

   always_ff @(posedge clk) begin : fifo_mem
      if (push) begin
         mem_data[wr_ptr] <= imem_rsp_data;
         mem_pc[wr_ptr]   <= rsp_pc;
      end
   end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Randomized scoreboard bench for instr_prefetch_queue: an imem model plus an expected
// instruction queue derived from fetch order and redirect rules.
module tb_instr_prefetch_queue;

   localparam logic [31:0] RESET_PC = 32'h0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } inst_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      int unsigned due;
      logic        stale;
   } mem_t;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   instr_prefetch_queue dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model state
   inst_t       exp_q[$];
   mem_t        imem_q[$];
   logic [31:0] exp_addr;
   logic        m_boot;
   logic        m_rv;
   logic        m_pop;
   int unsigned cyc;
   int unsigned rel_cyc;
   int          first_valid;
   int unsigned accepts;
   int unsigned dut_pops;

   // Stimulus knobs
   int unsigned p_req_ready;
   int unsigned p_rsp;
   int unsigned p_inst_ready;
   int unsigned p_redirect;
   int unsigned p_spur;
   int unsigned acc_limit;
   int unsigned max_dly;
   logic        force_redir;
   logic [31:0] force_target;

   int unsigned checks;
   int unsigned failures;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic model_rv();
      int unsigned st;
      st = 0;
      foreach (imem_q[i]) if (imem_q[i].stale) st++;
      return !m_boot && (st == 0) && !redirect_valid && ((exp_q.size() + imem_q.size()) < 4);
   endfunction

   // Monitor: compares DUT outputs against the model, pops on consumption
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("req_valid", 32'(imem_req_valid), 32'(m_rv));
            chk("req_addr", imem_req_addr, exp_addr);
            chk("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
               chk("inst_pc", inst_pc, exp_q[0].pc);
               chk("inst_data", inst_data, exp_q[0].data);
            end
            if (inst_valid && first_valid < 0) first_valid = int'(cyc);
            if (inst_valid && inst_ready) dut_pops++;
            if (m_pop) void'(exp_q.pop_front());
         end
      end
   end

   task automatic step();
      mem_t e;
      @(posedge clk); #1;
      cyc++;
      imem_req_ready = (imem_q.size() < acc_limit) && ($urandom_range(99) < p_req_ready);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (imem_q.size() != 0) begin
         if (cyc >= imem_q[0].due && $urandom_range(99) < p_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = imem_q[0].data;
         end
      end else if ($urandom_range(99) < p_spur) begin
         imem_rsp_valid = 1'b1;
      end
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
      if (force_redir) begin
         redirect_valid = 1'b1;
         redirect_pc    = force_target;
         force_redir    = 1'b0;
      end else if ($urandom_range(999) < p_redirect) begin
         redirect_valid = 1'b1;
         if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      end
      inst_ready = ($urandom_range(99) < p_inst_ready);
      m_rv  = model_rv();
      m_pop = (exp_q.size() != 0) && inst_ready;

      @(negedge clk); #1;
      if (imem_rsp_valid && imem_q.size() != 0) begin
         e = imem_q.pop_front();
         if (!e.stale && !redirect_valid) exp_q.push_back('{pc: e.addr, data: e.data});
      end
      if (m_rv && imem_req_ready) begin
         imem_q.push_back('{addr: exp_addr, data: $urandom,
                            due: cyc + 1 + $urandom_range(max_dly), stale: 1'b0});
         exp_addr = exp_addr + 32'd4;
         accepts++;
      end
      if (redirect_valid) begin
         exp_q.delete();
         foreach (imem_q[i]) imem_q[i].stale = 1'b1;
         exp_addr = {redirect_pc[31:2], 2'b00};
      end
   endtask

   // Assert reset at once, check outputs, optionally keep returning late responses
   task automatic reset_seq(input int unsigned n_late);
      @(posedge clk); #1;
      cyc++;
      rst            = 1'b0;
      redirect_valid = 1'b0;
      inst_ready     = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = (n_late != 0);
      imem_rsp_data  = $urandom;
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_req_addr", imem_req_addr, RESET_PC);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst_data", inst_data, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
      exp_q.delete();
      imem_q.delete();
      exp_addr    = RESET_PC;
      m_boot      = 1'b1;
      m_rv        = 1'b0;
      m_pop       = 1'b0;
      first_valid = -1;
      accepts     = 0;
      dut_pops    = 0;
      repeat (2) begin
         @(posedge clk); #1;
         cyc++;
         imem_rsp_data = $urandom;
      end
      @(posedge clk); #1;
      cyc++;
      rst     = 1'b1;
      rel_cyc = cyc;
      m_rv    = model_rv();
      @(negedge clk); #1;
      m_boot = 1'b0;
   endtask

   task automatic set_knobs(input int unsigned rr, input int unsigned rs, input int unsigned ir,
                            input int unsigned lim, input int unsigned dly);
      p_req_ready  = rr;
      p_rsp        = rs;
      p_inst_ready = ir;
      acc_limit    = lim;
      max_dly      = dly;
   endtask

   initial begin : stimulus
      int unsigned a0;
      rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
      checks = 0; failures = 0; cyc = 0; rel_cyc = 0; first_valid = -1;
      accepts = 0; dut_pops = 0; exp_addr = RESET_PC; m_boot = 1'b1; m_rv = 1'b0; m_pop = 1'b0;
      p_redirect = 0; p_spur = 0; force_redir = 1'b0; force_target = '0;
      set_knobs(100, 100, 100, 100, 0);

      // Streaming from reset with a 1-cycle imem
      reset_seq(0);
      repeat (30) step();
      chk("first_inst_latency", 32'(first_valid - int'(rel_cyc)), 32'd3);
      chk("stream_throughput", dut_pops, 32'd28);

      // Core stalled: credits cap requests at DEPTH
      reset_seq(0);
      set_knobs(100, 100, 0, 100, 0);
      repeat (20) step();
      chk("stall_accepts", accepts, 32'd4);

      // Redirect with nothing in flight, coincident with a pop
      set_knobs(100, 100, 100, 0, 0);
      force_redir = 1'b1; force_target = 32'h0000_0200;
      step();
      set_knobs(100, 100, 100, 100, 0);
      repeat (10) step();

      // Redirect to 0x103 with two requests in flight
      set_knobs(100, 100, 100, 0, 0);
      repeat (8) step();
      set_knobs(100, 0, 100, 2, 0);
      repeat (6) step();
      chk("two_in_flight", imem_q.size(), 32'd2);
      force_redir = 1'b1; force_target = 32'h0000_0103;
      step();
      set_knobs(100, 100, 100, 100, 2);
      repeat (20) step();

      // Address wrap at the top of memory
      set_knobs(100, 100, 100, 100, 0);
      a0 = accepts;
      force_redir = 1'b1; force_target = 32'hFFFF_FFF4;
      repeat (16) step();
      chk("wrap_accepts", 32'(accepts - a0 >= 4), 32'd1);

      // Reset mid-stream with three requests in flight
      set_knobs(100, 0, 0, 3, 0);
      repeat (8) step();
      chk("three_in_flight", imem_q.size(), 32'd3);
      reset_seq(3);
      set_knobs(100, 100, 100, 100, 0);
      repeat (20) step();
      chk("post_reset_latency", 32'(first_valid - int'(rel_cyc)), 32'd3);

      // Randomized traffic with redirects and spurious responses
      for (int blk = 0; blk < 15; blk++) begin
         set_knobs($urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 20),
                   100, $urandom_range(3));
         p_redirect = $urandom_range(40);
         p_spur     = $urandom_range(30);
         repeat (200) step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
